// File: rtl/dsp_vector_addsub_pipe.sv
// SIMD vector add/subtract pipeline: LANES independent WIDTH-bit lanes, valid/ready handshake, STAGES register stages.
// Define DSP_VECTOR_ADDSUB_SAT_EN to build saturating arithmetic instead of wrap-around results.
module dsp_vector_addsub_pipe #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_y,
    output logic [LANES-1:0]       out_flag
);

    localparam int VW = LANES * WIDTH;
    localparam int DS = STAGES - 1;

    logic [STAGES:1] valid_q;
    logic [STAGES:1] loadEn;
    logic [VW-1:0]   a_q [1:DS];
    logic [VW-1:0]   b_q [1:DS];
    logic [DS:1]     sub_q;
    logic [VW-1:0]   y_q;
    logic [VW-1:0]   y_d;
    logic [LANES-1:0] flag_q;
    logic [LANES-1:0] flag_d;

    // A stage is blocked only when it and every stage after it are full and the consumer stalls.
    always_comb begin : loadChain
        logic blocked;
        blocked = !out_ready;
        loadEn  = '0;
        for (int k = STAGES; k >= 1; k--) begin
            blocked   = blocked && valid_q[k];
            loadEn[k] = !blocked;
        end
    end

    assign in_ready = loadEn[1];

    always_comb begin : laneMath
        logic [WIDTH:0]   res;
        logic [WIDTH-1:0] opA;
        logic [WIDTH-1:0] opB;
        y_d    = '0;
        flag_d = '0;
        res    = '0;
        opA    = '0;
        opB    = '0;
        for (int l = 0; l < LANES; l++) begin
            opA = a_q[DS][l*WIDTH +: WIDTH];
            opB = b_q[DS][l*WIDTH +: WIDTH];
            // The extra top bit is the carry on add and the borrow (a < b) on subtract.
            if (sub_q[DS]) begin
                res = {1'b0, opA} - {1'b0, opB};
            end else begin
                res = {1'b0, opA} + {1'b0, opB};
            end
            flag_d[l] = res[WIDTH];
`ifdef DSP_VECTOR_ADDSUB_SAT_EN
            if (res[WIDTH]) begin
                y_d[l*WIDTH +: WIDTH] = sub_q[DS] ? '0 : '1;
            end else begin
                y_d[l*WIDTH +: WIDTH] = res[WIDTH-1:0];
            end
`else
            y_d[l*WIDTH +: WIDTH] = res[WIDTH-1:0];
`endif
        end
    end

    // Data registers only move when a valid beat enters them, so an idle pipe holds its state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            sub_q   <= '0;
            y_q     <= '0;
            flag_q  <= '0;
            for (int k = 1; k <= DS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            if (loadEn[1]) begin
                valid_q[1] <= in_valid;
            end
            for (int k = 2; k <= STAGES; k++) begin
                if (loadEn[k]) begin
                    valid_q[k] <= valid_q[k-1];
                end
            end
            if (loadEn[1] && in_valid) begin
                a_q[1]   <= in_a;
                b_q[1]   <= in_b;
                sub_q[1] <= in_sub;
            end
            for (int k = 2; k <= DS; k++) begin
                if (loadEn[k] && valid_q[k-1]) begin
                    a_q[k]   <= a_q[k-1];
                    b_q[k]   <= b_q[k-1];
                    sub_q[k] <= sub_q[k-1];
                end
            end
            if (loadEn[STAGES] && valid_q[DS]) begin
                y_q    <= y_d;
                flag_q <= flag_d;
            end
        end
    end

    assign out_valid = valid_q[STAGES];
    assign out_y     = y_q;
    assign out_flag  = flag_q;

endmodule
